// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_read_arbiter
//  Description : Two-master to one-slave AXI read-channel arbiter. Round-robin
//                grant, one outstanding read, burst-length and RID checking
//                with a one-cycle prot_err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_read_arbiter #(
    parameter int ID_BITS   = 4,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    // master 0 AR
    input  logic [ID_BITS-1:0]   ARID_M0,
    input  logic [ADDR_BITS-1:0] ARADDR_M0,
    input  logic [LEN_BITS-1:0]  ARLEN_M0,
    input  logic [2:0]           ARSIZE_M0,
    input  logic [1:0]           ARBURST_M0,
    input  logic                 ARVALID_M0,
    output logic                 ARREADY_M0,
    // master 1 AR
    input  logic [ID_BITS-1:0]   ARID_M1,
    input  logic [ADDR_BITS-1:0] ARADDR_M1,
    input  logic [LEN_BITS-1:0]  ARLEN_M1,
    input  logic [2:0]           ARSIZE_M1,
    input  logic [1:0]           ARBURST_M1,
    input  logic                 ARVALID_M1,
    output logic                 ARREADY_M1,
    // master 0 R
    output logic [ID_BITS-1:0]   RID_M0,
    output logic [DATA_BITS-1:0] RDATA_M0,
    output logic [1:0]           RRESP_M0,
    output logic                 RLAST_M0,
    output logic                 RVALID_M0,
    input  logic                 RREADY_M0,
    // master 1 R
    output logic [ID_BITS-1:0]   RID_M1,
    output logic [DATA_BITS-1:0] RDATA_M1,
    output logic [1:0]           RRESP_M1,
    output logic                 RLAST_M1,
    output logic                 RVALID_M1,
    input  logic                 RREADY_M1,
    // slave AR
    output logic [ID_BITS:0]     ARID_S,
    output logic [ADDR_BITS-1:0] ARADDR_S,
    output logic [LEN_BITS-1:0]  ARLEN_S,
    output logic [2:0]           ARSIZE_S,
    output logic [1:0]           ARBURST_S,
    output logic                 ARVALID_S,
    input  logic                 ARREADY_S,
    // slave R
    input  logic [ID_BITS:0]     RID_S,
    input  logic [DATA_BITS-1:0] RDATA_S,
    input  logic [1:0]           RRESP_S,
    input  logic                 RLAST_S,
    input  logic                 RVALID_S,
    output logic                 RREADY_S,
    // protocol error pulse
    output logic                 prot_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [LEN_BITS:0] c_BEAT_ONE = {{LEN_BITS{1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_prio;
    logic                  r_grant;
    logic                  w_grant_next;
    logic [LEN_BITS-1:0]   r_len_q;
    logic [LEN_BITS:0]     r_beat;
    logic                  r_overrun;
    logic                  r_prot_err;

    // granted-master views of the request/response handshake signals
    logic                  w_g_arvalid;
    logic                  w_g_rready;
    logic [ID_BITS-1:0]    w_g_arid;
    logic [ADDR_BITS-1:0]  w_g_araddr;
    logic [LEN_BITS-1:0]   w_g_arlen;
    logic [2:0]            w_g_arsize;
    logic [1:0]            w_g_arburst;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_beat_is_len;
    logic                  w_err_last;
    logic                  w_err_over;
    logic                  w_err_id;

    assign w_g_arvalid = r_grant ? ARVALID_M1 : ARVALID_M0;
    assign w_g_rready  = r_grant ? RREADY_M1  : RREADY_M0;
    assign w_g_arid    = r_grant ? ARID_M1    : ARID_M0;
    assign w_g_araddr  = r_grant ? ARADDR_M1  : ARADDR_M0;
    assign w_g_arlen   = r_grant ? ARLEN_M1   : ARLEN_M0;
    assign w_g_arsize  = r_grant ? ARSIZE_M1  : ARSIZE_M0;
    assign w_g_arburst = r_grant ? ARBURST_M1 : ARBURST_M0;

    assign w_ar_hs       = (r_state == S_ADDR) && w_g_arvalid && ARREADY_S;
    assign w_r_hs        = (r_state == S_DATA) && RVALID_S && w_g_rready;
    assign w_beat_is_len = (r_beat == {1'b0, r_len_q});
    // early RLAST; suppressed once an overrun has already been reported
    assign w_err_last    = w_r_hs && RLAST_S && !w_beat_is_len && !r_overrun;
    // the (len+1)-th beat went by without RLAST
    assign w_err_over    = w_r_hs && !RLAST_S && w_beat_is_len;
    assign w_err_id      = w_r_hs && (RID_S[ID_BITS] != r_grant);

    assign prot_err = r_prot_err;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and grant selection
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        case (r_state)
            S_IDLE: begin
                if (ARVALID_M0 || ARVALID_M1) begin
                    w_state_next = S_ADDR;
                    w_grant_next = (ARVALID_M0 && ARVALID_M1) ? r_prio : ARVALID_M1;
                end
            end
            S_ADDR: begin
                if (w_ar_hs) begin
                    w_state_next = S_DATA;
                end else if (!w_g_arvalid) begin
                    w_state_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (w_r_hs && RLAST_S) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Grant, priority, burst tracking and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant    <= 1'b0;
            r_prio     <= 1'b0;
            r_len_q    <= '0;
            r_beat     <= '0;
            r_overrun  <= 1'b0;
            r_prot_err <= 1'b0;
        end else begin
            r_grant    <= w_grant_next;
            r_prot_err <= w_err_last || w_err_over || w_err_id;
            if (w_ar_hs) begin
                r_len_q   <= w_g_arlen;
                r_beat    <= '0;
                r_overrun <= 1'b0;
            end else if (w_r_hs) begin
                // saturate so a long overrun never wraps back onto len_q
                if (r_beat != '1) begin
                    r_beat <= r_beat + c_BEAT_ONE;
                end
                if (w_err_over) begin
                    r_overrun <= 1'b1;
                end
            end
            if (w_r_hs && RLAST_S) begin
                r_prio <= ~r_grant;
            end
        end
    end

    // Output steering: AR towards the slave in ADDR, R towards the granted master in DATA
    always_comb begin
        ARREADY_M0 = 1'b0;
        ARREADY_M1 = 1'b0;
        ARID_S     = '0;
        ARADDR_S   = '0;
        ARLEN_S    = '0;
        ARSIZE_S   = '0;
        ARBURST_S  = '0;
        ARVALID_S  = 1'b0;
        RREADY_S   = 1'b0;
        RID_M0     = '0;
        RDATA_M0   = '0;
        RRESP_M0   = '0;
        RLAST_M0   = 1'b0;
        RVALID_M0  = 1'b0;
        RID_M1     = '0;
        RDATA_M1   = '0;
        RRESP_M1   = '0;
        RLAST_M1   = 1'b0;
        RVALID_M1  = 1'b0;
        if (r_state == S_ADDR) begin
            ARID_S    = {r_grant, w_g_arid};
            ARADDR_S  = w_g_araddr;
            ARLEN_S   = w_g_arlen;
            ARSIZE_S  = w_g_arsize;
            ARBURST_S = w_g_arburst;
            ARVALID_S = w_g_arvalid;
            if (r_grant) begin
                ARREADY_M1 = ARREADY_S;
            end else begin
                ARREADY_M0 = ARREADY_S;
            end
        end
        if (r_state == S_DATA) begin
            RREADY_S = w_g_rready;
            if (r_grant) begin
                RID_M1    = RID_S[ID_BITS-1:0];
                RDATA_M1  = RDATA_S;
                RRESP_M1  = RRESP_S;
                RLAST_M1  = RLAST_S;
                RVALID_M1 = RVALID_S;
            end else begin
                RID_M0    = RID_S[ID_BITS-1:0];
                RDATA_M0  = RDATA_S;
                RRESP_M0  = RRESP_S;
                RLAST_M0  = RLAST_S;
                RVALID_M0 = RVALID_S;
            end
        end
    end

endmodule
`default_nettype wire
